// File: rtl/lcd_pkg.sv
// Shared encodings for the LCD sequencer: script entry kinds, FSM states and entry sizing.
package lcd_pkg;

  localparam logic [1:0] KIND_CMD = 2'd0;
  localparam logic [1:0] KIND_DAT = 2'd1;
  localparam logic [1:0] KIND_DLY = 2'd2;
  localparam logic [1:0] KIND_END = 2'd3;

  typedef enum logic [2:0] {
    ST_RST_LO,
    ST_RST_WAIT,
    ST_FETCH,
    ST_DELAY,
    ST_ISSUE,
    ST_BUSY,
    ST_IDLE
  } state_t;

  // A script entry is {kind[1:0], payload[width-1:0]}.
  function automatic int entry_width(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Panel init script ROM: entry i sits at SCRIPT[i*(WIDTH+2) +: WIDTH+2], read combinationally.
// The default content is all END entries, i.e. an empty script.
module lcd_init_rom
  import lcd_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SCRIPT_AW = 5,
  parameter logic [(2**SCRIPT_AW)*(WIDTH+2)-1:0] SCRIPT = '1
) (
  input  logic [SCRIPT_AW-1:0] rom_addr,
  output logic [WIDTH+1:0]     rom_entry
);

  localparam int EW = entry_width(WIDTH);

  assign rom_entry = SCRIPT[int'(rom_addr) * EW +: EW];

endmodule

// File: rtl/lcd_sequencer.sv
// Drives the SPI LCD serializer: panel reset pulse, ROM init script, then one client write port.
// One byte per ISSUE pulse; ISSUE waits for ser_ordy, and the client sees wr_ready only in IDLE.
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SCRIPT_AW  = 5,
  parameter int RST_CYCLES = 1000,
  parameter int DELAY_UNIT = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [SCRIPT_AW-1:0] rom_addr,
  input  logic [WIDTH+1:0]     rom_entry,
  output logic                 ser_irdy,
  output logic [WIDTH-1:0]     ser_data,
  input  logic                 ser_ordy,
  output logic                 lcd_cs_n,
  output logic                 lcd_dc,
  output logic                 lcd_rst_n,
  input  logic                 wr_valid,
  input  logic                 wr_dc,
  input  logic [WIDTH-1:0]     wr_data,
  output logic                 wr_ready,
  output logic                 init_done
);

  // One counter serves both the reset phases and script delays.
  localparam int DLY_MAX = (2**WIDTH - 1) * DELAY_UNIT;
  localparam int CNT_MAX = (RST_CYCLES > DLY_MAX) ? RST_CYCLES : DLY_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]     RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [SCRIPT_AW-1:0] ADDR_LAST = '1;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] dly_load;
  logic [1:0]       kind;
  logic [WIDTH-1:0] payload;
  logic             cs_active;

  logic cnt_clr, cnt_inc, cnt_dec, cnt_ld;
  logic addr_inc, ld_init, ld_client, set_done;

  assign {kind, payload} = rom_entry;

  // DELAY counts dly_load down to zero inclusive: payload*DELAY_UNIT cycles.
  assign dly_load = CNT_W'(int'(payload) * DELAY_UNIT - 1);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_RST_LO;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    cnt_dec   = 1'b0;
    cnt_ld    = 1'b0;
    addr_inc  = 1'b0;
    ld_init   = 1'b0;
    ld_client = 1'b0;
    set_done  = 1'b0;
    ser_irdy  = 1'b0;
    wr_ready  = 1'b0;
    case (state)
      ST_RST_LO: begin
        if (cnt == RST_LAST) begin
          cnt_clr   = 1'b1;
          state_nxt = ST_RST_WAIT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_RST_WAIT: begin
        if (cnt == RST_LAST) begin
          cnt_clr   = 1'b1;
          state_nxt = ST_FETCH;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_FETCH: begin
        // The last ROM slot is never executed, so rom_addr cannot wrap.
        if (rom_addr == ADDR_LAST || kind == KIND_END) begin
          set_done  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (kind == KIND_DLY) begin
          if (payload == '0) begin
            addr_inc = 1'b1;
          end else begin
            cnt_ld    = 1'b1;
            state_nxt = ST_DELAY;
          end
        end else begin
          ld_init   = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_DELAY: begin
        if (cnt == '0) begin
          addr_inc  = 1'b1;
          state_nxt = ST_FETCH;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_ISSUE: begin
        ser_irdy = ser_ordy;
        if (ser_ordy) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (ser_ordy) begin
          if (init_done) begin
            state_nxt = ST_IDLE;
          end else begin
            addr_inc  = 1'b1;
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          ld_client = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      default: state_nxt = ST_RST_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      rom_addr  <= '0;
      ser_data  <= '0;
      lcd_dc    <= 1'b0;
      init_done <= 1'b0;
      cs_active <= 1'b0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      else if (cnt_dec) cnt <= cnt - 1'b1;
      else if (cnt_ld)  cnt <= dly_load;

      if (addr_inc) rom_addr <= rom_addr + 1'b1;

      if (ld_init) begin
        ser_data  <= payload;
        lcd_dc    <= (kind == KIND_DAT);
        cs_active <= 1'b1;
      end else if (ld_client) begin
        ser_data <= wr_data;
        lcd_dc   <= wr_dc;
      end

      if (set_done) init_done <= 1'b1;
    end
  end

  // Chip select stays low across the whole script once the first byte goes out.
  assign lcd_cs_n  = !((state == ST_ISSUE) || (state == ST_BUSY) || (cs_active && !init_done));
  assign lcd_rst_n = (state != ST_RST_LO);

endmodule

// File: tb/tb_lcd_sequencer.sv
// Scoreboard bench for lcd_sequencer with a WIDTH-cycle serializer model and two script ROMs.
module tb_lcd_sequencer;
  import lcd_pkg::*;

  localparam int WIDTH      = 8;
  localparam int SCRIPT_AW  = 5;
  localparam int RST_CYCLES = 4;
  localparam int DELAY_UNIT = 4;
  localparam int EW         = WIDTH + 2;
  localparam int NENT       = 32;

  function automatic logic [EW*NENT-1:0] make_script_a();
    logic [EW*NENT-1:0] s;
    s = '1;
    s[0*EW +: EW] = {KIND_CMD, 8'h11};
    s[1*EW +: EW] = {KIND_DLY, 8'd2};
    s[2*EW +: EW] = {KIND_DAT, 8'hA5};
    s[3*EW +: EW] = {KIND_END, 8'h00};
    return s;
  endfunction

  function automatic logic [EW*NENT-1:0] make_script_b();
    logic [EW*NENT-1:0] s;
    s = '1;
    for (int i = 0; i < NENT; i++) s[i*EW +: EW] = {KIND_CMD, 8'(8'h80 + i)};
    return s;
  endfunction

  localparam logic [EW*NENT-1:0] SCRIPT_A = make_script_a();
  localparam logic [EW*NENT-1:0] SCRIPT_B = make_script_b();

  logic                 clk = 1'b0;
  logic                 reset;
  logic [SCRIPT_AW-1:0] rom_addr;
  logic [EW-1:0]        rom_entry, entry_a, entry_b;
  logic                 use_b;
  logic                 ser_irdy, ser_ordy;
  logic [WIDTH-1:0]     ser_data;
  logic                 lcd_cs_n, lcd_dc, lcd_rst_n;
  logic                 wr_valid, wr_dc, wr_ready, init_done;
  logic [WIDTH-1:0]     wr_data;

  always #5 clk = ~clk;

  lcd_init_rom #(.WIDTH(WIDTH), .SCRIPT_AW(SCRIPT_AW), .SCRIPT(SCRIPT_A))
    u_rom_a (.rom_addr(rom_addr), .rom_entry(entry_a));
  lcd_init_rom #(.WIDTH(WIDTH), .SCRIPT_AW(SCRIPT_AW), .SCRIPT(SCRIPT_B))
    u_rom_b (.rom_addr(rom_addr), .rom_entry(entry_b));
  assign rom_entry = use_b ? entry_b : entry_a;

  lcd_sequencer #(
    .WIDTH(WIDTH), .SCRIPT_AW(SCRIPT_AW), .RST_CYCLES(RST_CYCLES), .DELAY_UNIT(DELAY_UNIT)
  ) dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_entry(rom_entry),
    .ser_irdy(ser_irdy), .ser_data(ser_data), .ser_ordy(ser_ordy),
    .lcd_cs_n(lcd_cs_n), .lcd_dc(lcd_dc), .lcd_rst_n(lcd_rst_n),
    .wr_valid(wr_valid), .wr_dc(wr_dc), .wr_data(wr_data),
    .wr_ready(wr_ready), .init_done(init_done)
  );

  // Serializer: shifts WIDTH cycles after accepting a byte, idle otherwise.
  int sbusy = 0;
  always @(posedge clk) begin
    if (reset)                     sbusy <= 0;
    else if (ser_irdy && ser_ordy) sbusy <= WIDTH;
    else if (sbusy != 0)           sbusy <= sbusy - 1;
  end
  assign ser_ordy = (sbusy == 0);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
  endtask

  // Per-cycle log of DUT outputs, sampled on the falling edge.
  logic             rst_n_l [0:4095];
  logic             cs_n_l  [0:4095];
  logic             irdy_l  [0:4095];
  logic             rdy_l   [0:4095];
  logic             done_l  [0:4095];
  logic [WIDTH-1:0] data_l  [0:4095];
  logic [4:0]       addr_l  [0:4095];

  function automatic logic [11:0] ix(input int t);
    return t[11:0];
  endfunction

  always @(negedge clk) begin
    rst_n_l[ix(cyc)] = lcd_rst_n;
    cs_n_l[ix(cyc)]  = lcd_cs_n;
    irdy_l[ix(cyc)]  = ser_irdy;
    rdy_l[ix(cyc)]   = wr_ready;
    done_l[ix(cyc)]  = init_done;
    data_l[ix(cyc)]  = ser_data;
    addr_l[ix(cyc)]  = rom_addr;
  end

  function automatic int count_irdy(input int a, input int b);
    int n = 0;
    for (int t = a; t <= b; t++) if (irdy_l[ix(t)] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_cs_hi(input int a, input int b);
    int n = 0;
    for (int t = a; t <= b; t++) if (cs_n_l[ix(t)] !== 1'b0) n++;
    return n;
  endfunction

  // Scoreboard: expected bytes are queued at stimulus time, popped on each ser_irdy pulse.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             dc;
  } exp_t;

  exp_t             exp_q[$];
  int               irdy_q[$];
  exp_t             got_e;
  logic [WIDTH-1:0] held = '0;
  logic             stab_err = 1'b0;

  task automatic push_exp(input logic [WIDTH-1:0] d, input logic dc);
    exp_t e;
    e.data = d;
    e.dc   = dc;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && ser_irdy) begin
      irdy_q.push_back(cyc);
      held = ser_data;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_byte: got 0x%0h dc=%0b, expected no byte", ser_data, lcd_dc);
      end else begin
        got_e = exp_q.pop_front();
        chk("byte_data", 32'(ser_data), 32'(got_e.data));
        chk("byte_dc", 32'(lcd_dc), 32'(got_e.dc));
        chk("byte_cs_n", 32'(lcd_cs_n), 32'h0);
      end
    end else if (!reset && !ser_ordy && ser_data !== held) begin
      stab_err = 1'b1;
    end
  end

  int t0;

  task automatic wait_past(input int t);
    while (cyc <= t) @(negedge clk);
  endtask

  task automatic do_reset(input logic sel_b);
    reset    = 1'b1;
    use_b    = sel_b;
    wr_valid = 1'b0;
    @(negedge clk);
    chk("rst_val_rst_n", 32'(lcd_rst_n), 32'h0);
    chk("rst_val_cs_n", 32'(lcd_cs_n), 32'h1);
    chk("rst_val_irdy", 32'(ser_irdy), 32'h0);
    chk("rst_val_data", 32'(ser_data), 32'h0);
    chk("rst_val_dc", 32'(lcd_dc), 32'h0);
    chk("rst_val_ready", 32'(wr_ready), 32'h0);
    chk("rst_val_done", 32'(init_done), 32'h0);
    chk("rst_val_addr", 32'(rom_addr), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    t0    = cyc;
  endtask

  // Script A timeline from release: rst low 0..3, wait 4..7, FETCH 8, ISSUE 9,
  // BUSY 10..18, FETCH 19, DELAY 20..27, FETCH 28, ISSUE 29, BUSY 30..38, FETCH 39, IDLE 40.
  task automatic check_script_a();
    int cs_hi;
    wait_past(t0 + 39);
    chk("rst_lo_last", 32'(rst_n_l[ix(t0 + 3)]), 32'h0);
    chk("rst_hi_first", 32'(rst_n_l[ix(t0 + 4)]), 32'h1);
    chk("rst_hi_settle_end", 32'(rst_n_l[ix(t0 + 7)]), 32'h1);
    cs_hi = count_cs_hi(t0 + 1, t0 + 8);
    chk("cs_n_high_pre_fetch", cs_hi, 8);
    chk("first_fetch_addr", 32'(addr_l[ix(t0 + 8)]), 32'h0);
    chk("init_issue_count", irdy_q.size(), 2);
    if (irdy_q.size() >= 2) begin
      chk("first_issue_cycle", irdy_q[0] - t0, 9);
      chk("second_issue_cycle", irdy_q[1] - t0, 29);
    end
    chk("cs_n_low_in_delay", 32'(cs_n_l[ix(t0 + 24)]), 32'h0);
    chk("addr_delay_last", 32'(addr_l[ix(t0 + 27)]), 32'h1);
    chk("addr_after_delay", 32'(addr_l[ix(t0 + 28)]), 32'h2);
    chk("ready_during_init", count_irdy(t0 + 1, t0 + 0) + (rdy_l[ix(t0 + 20)] === 1'b1 ? 1 : 0)
        + (rdy_l[ix(t0 + 39)] === 1'b1 ? 1 : 0), 0);
    chk("done_before_end", 32'(done_l[ix(t0 + 39)]), 32'h0);
    chk("done_after_end", 32'(init_done), 32'h1);
    chk("ready_after_init", 32'(wr_ready), 32'h1);
    chk("cs_n_idle", 32'(lcd_cs_n), 32'h1);
  endtask

  int c, c2, c3;
  int last_cyc;
  logic seen_nz, wrapped, stable;

  initial begin
    reset = 1'b1; use_b = 1'b0;
    wr_valid = 1'b0; wr_dc = 1'b0; wr_data = '0;

    do_reset(1'b0);
    push_exp(8'h11, 1'b0);
    push_exp(8'hA5, 1'b1);
    irdy_q.delete();
    check_script_a();

    // Single client write accepted in IDLE; inputs change right after acceptance.
    c = cyc;
    irdy_q.delete();
    push_exp(8'h3C, 1'b1);
    wr_valid = 1'b1; wr_data = 8'h3C; wr_dc = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0; wr_data = 8'h00; wr_dc = 1'b0;
    wait_past(c + 11);
    chk("client_issue_at_c1", 32'(irdy_l[ix(c + 1)]), 32'h1);
    chk("client_issue_pulses", count_irdy(c + 1, c + 11), 1);
    stable = 1'b1;
    for (int t = c + 1; t <= c + 10; t++) if (data_l[ix(t)] !== 8'h3C) stable = 1'b0;
    chk("client_data_stable", 32'(stable), 32'h1);
    chk("client_ready_c10", 32'(rdy_l[ix(c + 10)]), 32'h0);
    chk("client_ready_c11", 32'(rdy_l[ix(c + 11)]), 32'h1);

    // Back-to-back writes with wr_valid held.
    c2 = cyc;
    irdy_q.delete();
    push_exp(8'h01, 1'b0);
    push_exp(8'h02, 1'b1);
    wr_valid = 1'b1; wr_data = 8'h01; wr_dc = 1'b0;
    @(negedge clk);
    wr_data = 8'h02; wr_dc = 1'b1;
    wait_past(c2 + 11);
    wr_valid = 1'b0; wr_data = 8'h00; wr_dc = 1'b0;
    wait_past(c2 + 27);
    chk("b2b_issue_count", irdy_q.size(), 2);
    if (irdy_q.size() >= 2) begin
      chk("b2b_first_issue", irdy_q[0] - c2, 1);
      chk("b2b_issue_spacing", irdy_q[1] - irdy_q[0], 11);
    end
    chk("b2b_cs_n_high_cycles", count_cs_hi(c2 + 1, c2 + 21), 1);
    chk("b2b_cs_n_idle_gap", 32'(cs_n_l[ix(c2 + 11)]), 32'h1);
    chk("idle_no_transfer", count_irdy(c2 + 22, c2 + 27), 0);

    // Reset three cycles into BUSY, then the whole sequence must replay.
    c3 = cyc;
    push_exp(8'h77, 1'b0);
    wr_valid = 1'b1; wr_data = 8'h77; wr_dc = 1'b0;
    @(negedge clk);
    wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_before_reset", 32'(ser_ordy), 32'h0);
    chk("cs_n_before_reset", 32'(lcd_cs_n), 32'h0);
    do_reset(1'b0);
    push_exp(8'h11, 1'b0);
    push_exp(8'hA5, 1'b1);
    irdy_q.delete();
    check_script_a();

    // 32 CMD entries and no END: entries 0..30 sent, slot 31 acts as END.
    do_reset(1'b1);
    for (int i = 0; i < NENT - 1; i++) push_exp(8'(8'h80 + i), 1'b0);
    irdy_q.delete();
    for (int k = 0; k < 600 && !init_done; k++) @(negedge clk);
    chk("full_init_done", 32'(init_done), 32'h1);
    chk("full_done_cycle", cyc - t0, 350);
    chk("full_byte_count", irdy_q.size(), 31);
    if (irdy_q.size() == 31) chk("full_last_issue", irdy_q[30] - t0, 339);
    chk("full_final_addr", 32'(rom_addr), 32'h1F);
    last_cyc = cyc;
    seen_nz = 1'b0;
    wrapped = 1'b0;
    for (int t = t0 + 8; t < last_cyc; t++) begin
      if (addr_l[ix(t)] != 5'd0) seen_nz = 1'b1;
      else if (seen_nz) wrapped = 1'b1;
    end
    chk("full_addr_no_wrap", 32'(wrapped), 32'h0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("ser_data_stable", 32'(stab_err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

endmodule
